// File: rtl/tape_progress_tracker_pkg.sv
// ---------------------------------------------------------------------------
// tape_progress_pkg
// Shared types and helpers for the tape-load progress tracker.
//   ADDR_W_DEFAULT : default width of image size / position / progress values
//   POS_W          : working width of the position helper (covers any ADDR_W
//                    up to 31 bits with headroom for the +1 carry)
//   tape_state_e   : tracker state (EMPTY, READY, RUN, HOLD)
//   clamp_pos()    : min(addr + 1, lim) computed without wrap-around
// Optional feature macro used by the files of this block: TAPE_PROGRESS_HOLD_EN
// ---------------------------------------------------------------------------
package tape_progress_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 25;
  localparam int unsigned POS_W          = 32;

  typedef enum logic [1:0] {
    EMPTY,
    READY,
    RUN,
    HOLD
  } tape_state_e;

  // Position after fetching byte 'addr', clamped to 'lim'. The increment is
  // done one bit wider than the operands so an all-ones address cannot wrap.
  function automatic logic [POS_W-1:0] clamp_pos(
    input logic [POS_W-1:0] addr,
    input logic [POS_W-1:0] lim
  );
    logic [POS_W:0] nxt;
    nxt = {1'b0, addr} + {{POS_W{1'b0}}, 1'b1};
    if (nxt > {1'b0, lim}) begin
      return lim;
    end
    return nxt[POS_W-1:0];
  endfunction

endpackage

// File: rtl/tape_progress_tracker_if.sv
// ---------------------------------------------------------------------------
// tape_progress_tracker_if
// Bundles the tracker's machine-side inputs and overlay-side outputs.
//   img_mounted / img_size   : mount pulse and image size in bytes
//   tape_motor               : motor level
//   rd_strobe / rd_addr      : per-byte fetch pulse and its address
//   osd_force                : force bar visible while an image is loaded
//   current / max / enable   : progress bar feed
//   done                     : one-cycle pulse when current first reaches max
// Modports: master = environment (drives inputs), slave = tracker.
// ---------------------------------------------------------------------------
interface tape_progress_tracker_if
  import tape_progress_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
);

  logic              img_mounted;
  logic [ADDR_W-1:0] img_size;
  logic              tape_motor;
  logic              rd_strobe;
  logic [ADDR_W-1:0] rd_addr;
  logic              osd_force;
  logic [ADDR_W-1:0] current;
  logic [ADDR_W-1:0] max;
  logic              enable;
  logic              done;

  modport master (
    output img_mounted, img_size, tape_motor, rd_strobe, rd_addr, osd_force,
    input  current, max, enable, done
  );

  modport slave (
    input  img_mounted, img_size, tape_motor, rd_strobe, rd_addr, osd_force,
    output current, max, enable, done
  );

endinterface

// File: rtl/tape_progress_tracker_hold_timer.sv
// ---------------------------------------------------------------------------
// hold_timer
// 32-bit down-counter that times the visible-after-motor-stop period.
//   clk, reset_n : clock, synchronous active-low reset (count cleared)
//   clear        : force count to 0 (highest priority)
//   load         : load load_val
//   dec          : decrement by one while count is non-zero
//   count        : current count
//   expired      : count is zero
// Only instantiated when TAPE_PROGRESS_HOLD_EN is defined.
// ---------------------------------------------------------------------------
module hold_timer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        dec,
  output logic [31:0] count,
  output logic        expired
);

  logic [31:0] count_q;
  logic [31:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign expired = (count_q == '0);

endmodule

// File: rtl/tape_progress_tracker.sv
// ---------------------------------------------------------------------------
// tape_progress_tracker
// Feeds the tape-load progress bar overlay: latches the mounted image size,
// follows the reader's byte position and decides when the bar is visible.
//   clk      : system clock
//   reset_n  : synchronous reset, active low
//   bus      : tape_progress_tracker_if.slave
//              (img_mounted, img_size, tape_motor, rd_strobe, rd_addr,
//               osd_force in; current, max, enable, done out)
// Parameters: CLK_HZ, HOLD_MS (bar hold time after motor stop), ADDR_W.
// Optional feature macro: TAPE_PROGRESS_HOLD_EN -- when defined, the bar stays
// visible for HOLD_MS after the motor stops (HOLD state + hold_timer); when
// undefined, RUN returns straight to READY and HOLD_MS is ignored.
// ---------------------------------------------------------------------------
module tape_progress_tracker
  import tape_progress_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 64000000,
  parameter int unsigned HOLD_MS = 1000,
  parameter int unsigned ADDR_W  = ADDR_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset_n,
  tape_progress_tracker_if.slave   bus
);

  tape_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cur_q,   cur_d;
  logic [ADDR_W-1:0] max_q,   max_d;
  logic              armed_q, armed_d;
  logic              enable_q, enable_d;
  logic              done_q,  done_d;
  logic [ADDR_W-1:0] pos_new;

  assign pos_new = ADDR_W'(clamp_pos(POS_W'(bus.rd_addr), POS_W'(max_q)));

`ifdef TAPE_PROGRESS_HOLD_EN
  localparam logic [31:0] HOLD_PROD = 32'((CLK_HZ / 1000) * HOLD_MS);
  // HOLD_MS = 0 maps to 0 so HOLD still lasts one clock instead of wrapping.
  localparam logic [31:0] HOLD_CYC  = (HOLD_PROD == '0) ? '0 : (HOLD_PROD - 32'd1);

  logic        hold_load;
  logic        hold_clear;
  logic        hold_dec;
  logic        hold_expired;
  logic [31:0] hold_count;

  assign hold_dec = (state_q == HOLD);

  hold_timer u_hold_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (hold_clear),
    .load     (hold_load),
    .load_val (HOLD_CYC),
    .dec      (hold_dec),
    .count    (hold_count),
    .expired  (hold_expired)
  );
`else
  // Hold timing parameters have no effect in this build.
  logic [31:0] unused_hold_cfg;
  assign unused_hold_cfg = 32'(CLK_HZ) ^ 32'(HOLD_MS);
`endif

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    max_d   = max_q;
    armed_d = armed_q;
    done_d  = 1'b0;
`ifdef TAPE_PROGRESS_HOLD_EN
    hold_load  = 1'b0;
    hold_clear = 1'b0;
`endif

    if (bus.img_mounted) begin
      // Mount overrides everything, including a fetch in the same cycle.
      max_d   = bus.img_size;
      cur_d   = '0;
      armed_d = 1'b1;
      state_d = (bus.img_size != '0) ? READY : EMPTY;
`ifdef TAPE_PROGRESS_HOLD_EN
      hold_clear = 1'b1;
`endif
    end else if (state_q != EMPTY) begin
      if (bus.rd_strobe) begin
        cur_d = pos_new;
        // pos_new never exceeds max, so "not equal" means "below max".
        if (pos_new == max_q) begin
          if (armed_q) begin
            done_d  = 1'b1;
            armed_d = 1'b0;
          end
        end else begin
          armed_d = 1'b1;
        end
      end

      unique case (state_q)
        READY: begin
          if (bus.tape_motor) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (!bus.tape_motor) begin
`ifdef TAPE_PROGRESS_HOLD_EN
            state_d   = HOLD;
            hold_load = 1'b1;
`else
            state_d = READY;
`endif
          end
        end
`ifdef TAPE_PROGRESS_HOLD_EN
        HOLD: begin
          if (bus.tape_motor) begin
            state_d    = RUN;
            hold_clear = 1'b1;
          end else if (hold_expired) begin
            state_d = READY;
          end
        end
`endif
        default: begin
          state_d = state_q;
        end
      endcase
    end

    enable_d = (state_d == RUN) || (state_d == HOLD) ||
               (bus.osd_force && (state_d != EMPTY));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= EMPTY;
      cur_q    <= '0;
      max_q    <= '0;
      armed_q  <= 1'b1;
      enable_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      max_q    <= max_d;
      armed_q  <= armed_d;
      enable_q <= enable_d;
      done_q   <= done_d;
    end
  end

  assign bus.current = cur_q;
  assign bus.max     = max_q;
  assign bus.enable  = enable_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_tape_progress_tracker.sv
// ---------------------------------------------------------------------------
// tb_tape_progress_tracker
// Directed bench for tape_progress_tracker with CLK_HZ=1000, HOLD_MS=10
// (hold period of 10 clocks when TAPE_PROGRESS_HOLD_EN is defined).
// Inputs change 1 time unit after a rising edge; outputs are checked there.
// ---------------------------------------------------------------------------
module tb_tape_progress_tracker;

  localparam int unsigned AW = 25;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_err;

  tape_progress_tracker_if #(.ADDR_W(AW)) bus ();

  tape_progress_tracker #(
    .CLK_HZ  (1000),
    .HOLD_MS (10),
    .ADDR_W  (AW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] cur, input logic [31:0] mx,
                         input logic en, input logic dn);
    chk({tag, ".current"}, 32'(bus.current), cur);
    chk({tag, ".max"},     32'(bus.max),     mx);
    chk({tag, ".enable"},  32'(bus.enable),  32'(en));
    chk({tag, ".done"},    32'(bus.done),    32'(dn));
  endtask

  task automatic strobe(input logic [AW-1:0] a);
    bus.rd_strobe = 1'b1;
    bus.rd_addr   = a;
    tick();
    bus.rd_strobe = 1'b0;
  endtask

  task automatic mount(input logic [AW-1:0] sz);
    bus.img_mounted = 1'b1;
    bus.img_size    = sz;
    tick();
    bus.img_mounted = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset_n         = 1'b0;
    bus.img_mounted = 1'b0;
    bus.img_size    = '0;
    bus.tape_motor  = 1'b0;
    bus.rd_strobe   = 1'b0;
    bus.rd_addr     = '0;
    bus.osd_force   = 1'b0;
    tick();
    tick();
    chk_all("reset", 0, 0, 1'b0, 1'b0);
    reset_n = 1'b1;

    // Mount 1000-byte image: READY, bar hidden
    mount(25'd1000);
    chk_all("mount", 0, 1000, 1'b0, 1'b0);

    // Motor on: bar appears on the next edge
    bus.tape_motor = 1'b1;
    tick();
    chk("motor_on.enable", 32'(bus.enable), 1);

    strobe(25'd499);
    chk("pos499.current", 32'(bus.current), 500);
    chk("pos499.done",    32'(bus.done),    0);

    // Clamp past end, done pulses once
    strobe(25'd1200);
    chk_all("clamp", 1000, 1000, 1'b1, 1'b1);
    tick();
    chk("clamp_next.done", 32'(bus.done), 0);
    strobe(25'd1200);
    chk("clamp_again.current", 32'(bus.current), 1000);
    chk("clamp_again.done",    32'(bus.done),    0);

    // Rewind re-arms done
    strobe(25'd10);
    chk("rewind.current", 32'(bus.current), 11);
    chk("rewind.done",    32'(bus.done),    0);
    strobe(25'd999);
    chk("rearm.current", 32'(bus.current), 1000);
    chk("rearm.done",    32'(bus.done),    1);
    tick();
    chk("rearm_next.done", 32'(bus.done), 0);

    // Motor fall together with a fetch: both take effect on the same edge
    bus.tape_motor = 1'b0;
    bus.rd_strobe  = 1'b1;
    bus.rd_addr    = 25'd20;
`ifdef TAPE_PROGRESS_HOLD_EN
    for (int i = 0; i < 10; i++) begin
      tick();
      bus.rd_strobe = 1'b0;
      chk($sformatf("hold%0d.enable", i), 32'(bus.enable), 1);
      if (i == 0) chk("fall_strobe.current", 32'(bus.current), 21);
    end
    tick();
    chk("hold_end.enable", 32'(bus.enable), 0);
    tick();
    chk("ready_idle.enable", 32'(bus.enable), 0);

    // Motor comes back while the hold count is 4
    bus.tape_motor = 1'b1;
    tick();
    chk("rerun.enable", 32'(bus.enable), 1);
    bus.tape_motor = 1'b0;
    tick();
    chk("rehold0.enable", 32'(bus.enable), 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("rehold%0d.enable", i + 1), 32'(bus.enable), 1);
    end
    bus.tape_motor = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("resume%0d.enable", i), 32'(bus.enable), 1);
    end
`else
    tick();
    bus.rd_strobe = 1'b0;
    chk("fall_strobe.current", 32'(bus.current), 21);
    chk("fall.enable", 32'(bus.enable), 0);
    bus.tape_motor = 1'b1;
    tick();
    chk("rerun.enable", 32'(bus.enable), 1);
`endif

    // Reset during RUN with a fetch pending
    bus.rd_strobe = 1'b1;
    bus.rd_addr   = 25'd300;
    reset_n       = 1'b0;
    tick();
    chk_all("reset_run", 0, 0, 1'b0, 1'b0);
    reset_n        = 1'b1;
    bus.rd_strobe  = 1'b0;

    // EMPTY ignores motor, fetch and osd_force
    bus.osd_force  = 1'b1;
    bus.tape_motor = 1'b1;
    strobe(25'd5);
    chk_all("empty", 0, 0, 1'b0, 1'b0);

    // Zero-size image stays EMPTY
    mount(25'd0);
    strobe(25'd7);
    chk_all("zero_img", 0, 0, 1'b0, 1'b0);

    // Remount 5 bytes with osd_force, motor off: visible in READY
    bus.tape_motor = 1'b0;
    mount(25'd5);
    chk_all("force", 0, 5, 1'b1, 1'b0);
    bus.osd_force = 1'b0;
    tick();
    chk("unforce.enable", 32'(bus.enable), 0);

    // Mount wins over a simultaneous fetch
    strobe(25'd2);
    chk("pre_prio.current", 32'(bus.current), 3);
    bus.rd_strobe = 1'b1;
    bus.rd_addr   = 25'd50;
    mount(25'd1000);
    bus.rd_strobe = 1'b0;
    chk_all("prio", 0, 1000, 1'b0, 1'b0);

    // Full-width image, all-ones address must not wrap
    mount(25'h1FFFFFF);
    strobe(25'h1FFFFFD);
    chk_all("near_top", 32'h1FFFFFE, 32'h1FFFFFF, 1'b0, 1'b0);
    strobe(25'h1FFFFFF);
    chk_all("top", 32'h1FFFFFF, 32'h1FFFFFF, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
